pc_gen: RTL and testbench

Parametrised program-counter generator for the instruction-fetch stage. It sequences instruction addresses and drives the instruction-memory chip enable. It also accepts branch and exception/flush redirects. A branch that arrives while fetch is stalled is buffered and applied when the stall releases, so the pipeline never loses a redirect. It sits ahead of IF/ID and takes `stall` from the global stall controller.

---
 rtl/pc_gen_pkg.sv | 14 +
 rtl/pc_gen_if.sv | 24 ++
 rtl/pc_redirect_buf.sv | 36 +++
 rtl/pc_gen.sv | 78 +++++++
 tb/tb_pc_gen.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
// Shared constants and state encoding for the instruction-fetch PC generator.
package pc_gen_pkg;

    typedef enum logic {
        OFF = 1'b0,
        RUN = 1'b1
    } state_t;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic Stop        = 1'b1;
    localparam logic NoStop      = 1'b0;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle: stall/redirect inputs and the PC / chip-enable outputs.
interface pc_gen_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned STALL_W = 6
);
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [ADDR_W-1:0]  flush_pc;
    logic               br_valid;
    logic [ADDR_W-1:0]  br_target;
    logic [ADDR_W-1:0]  pc;
    logic               ce;
    logic               br_pending;

    modport master (
        input  stall, flush, flush_pc, br_valid, br_target,
        output pc, ce, br_pending
    );

    modport slave (
        output stall, flush, flush_pc, br_valid, br_target,
        input  pc, ce, br_pending
    );
endinterface

// File: rtl/pc_redirect_buf.sv
// Holds a branch target that arrived during a stall until fetch can take it.
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              flush,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic              br_pending,
    output logic [ADDR_W-1:0] buf_target
);

    // Any unstalled enabled edge either consumes the buffer or lets a direct branch supersede it.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_pending <= 1'b0;
        end else if (flush) begin
            br_pending <= 1'b0;
        end else if (ce == ChipEnable) begin
            if (stall == Stop) begin
                if (br_valid) begin
                    br_pending <= 1'b1;
                    buf_target <= br_target;
                end
            end else begin
                br_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: sequencing, redirects and instruction-memory chip enable.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned       STEP      = 1,
    parameter int unsigned       STALL_W   = 6
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.master bus
);

    state_t            state_q;
    state_t            state_d;
    logic              ce;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              pending;
    logic [ADDR_W-1:0] buf_target;

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    always_comb begin
        state_d = RUN;
        ce      = ChipDisable;
        if (rst) begin
            state_d = OFF;
        end
        if (state_q == RUN) begin
            ce = ChipEnable;
        end
    end

    // Priority uses the registered chip enable, so the edge sampling rst still advances normally.
    always_comb begin
        pc_d = pc_q;
        if (ce == ChipDisable) begin
            pc_d = RESET_VEC;
        end else if (bus.flush) begin
            pc_d = bus.flush_pc;
        end else if (bus.stall[0] == Stop) begin
            pc_d = pc_q;
        end else if (bus.br_valid) begin
            pc_d = bus.br_target;
        end else if (pending) begin
            pc_d = buf_target;
        end else begin
            pc_d = pc_q + ADDR_W'(STEP);
        end
    end

    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    pc_redirect_buf #(
        .ADDR_W(ADDR_W)
    ) u_redirect_buf (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .flush     (bus.flush),
        .stall     (bus.stall[0]),
        .br_valid  (bus.br_valid),
        .br_target (bus.br_target),
        .br_pending(pending),
        .buf_target(buf_target)
    );

    assign bus.pc         = pc_q;
    assign bus.ce         = ce;
    assign bus.br_pending = pending;

endmodule

// File: tb/tb_pc_gen.sv
// Directed-vector bench for pc_gen with a queue-based scoreboard and a separate monitor.
module tb_pc_gen;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pc_gen_if #(.ADDR_W(32), .STALL_W(6)) bus ();
    pc_gen_if #(.ADDR_W(8),  .STALL_W(6)) bus8 ();

    pc_gen #(
        .ADDR_W   (32),
        .RESET_VEC(32'h100),
        .STEP     (1),
        .STALL_W  (6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    pc_gen #(
        .ADDR_W   (8),
        .RESET_VEC(8'hFC),
        .STEP     (1),
        .STALL_W  (6)
    ) dut8 (
        .clk(clk),
        .rst(rst),
        .bus(bus8)
    );

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic        ce;
        logic        pend;
        logic        chk_pc;
        logic [7:0]  pc8;
        logic        chk8;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   vec_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one expected entry per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check($sformatf("v%0d_ce", e.idx), {31'b0, bus.ce}, {31'b0, e.ce});
                check($sformatf("v%0d_pend", e.idx), {31'b0, bus.br_pending}, {31'b0, e.pend});
                if (e.chk_pc)
                    check($sformatf("v%0d_pc", e.idx), bus.pc, e.pc);
                if (e.chk8) begin
                    check($sformatf("v%0d_pc8", e.idx), {24'b0, bus8.pc}, {24'b0, e.pc8});
                    check($sformatf("v%0d_ce8", e.idx), {31'b0, bus8.ce}, {31'b0, e.ce});
                end
            end
        end
    end

    task automatic step(input bit r, input bit s, input bit f, input logic [31:0] fpc,
                        input bit bv, input logic [31:0] bt,
                        input logic [31:0] epc, input bit ece, input bit epend, input bit cpc,
                        input logic [7:0] epc8, input bit c8);
        exp_t e;
        @(negedge clk);
        rst           = r;
        bus.stall     = {5'b10110, s};
        bus.flush     = f;
        bus.flush_pc  = fpc;
        bus.br_valid  = bv;
        bus.br_target = bt;
        e.idx    = vec_n;
        e.pc     = epc;
        e.ce     = ece;
        e.pend   = epend;
        e.chk_pc = cpc;
        e.pc8    = epc8;
        e.chk8   = c8;
        sbq.push_back(e);
        vec_n++;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.stall     = '0;
        bus.flush     = 1'b0;
        bus.flush_pc  = '0;
        bus.br_valid  = 1'b0;
        bus.br_target = '0;
        bus8.stall     = '0;
        bus8.flush     = 1'b0;
        bus8.flush_pc  = '0;
        bus8.br_valid  = 1'b0;
        bus8.br_target = '0;

        //   r  s  f  fpc     bv bt        exp_pc   ce pend chk  pc8   chk8
        step(1, 0, 0, 32'h0,  0, 32'h0,    32'h0,   0, 0,   0,   8'h0,  0);
        step(1, 1, 0, 32'h0,  1, 32'h3FF,  32'h100, 0, 0,   1,   8'hFC, 1);
        step(0, 0, 0, 32'h0,  0, 32'h0,    32'h100, 1, 0,   1,   8'hFC, 1);
        step(0, 0, 0, 32'h0,  0, 32'h0,    32'h101, 1, 0,   1,   8'hFD, 1);
        step(0, 0, 0, 32'h0,  0, 32'h0,    32'h102, 1, 0,   1,   8'hFE, 1);
        step(0, 0, 0, 32'h0,  0, 32'h0,    32'h103, 1, 0,   1,   8'hFF, 1);
        step(0, 0, 0, 32'h0,  0, 32'h0,    32'h104, 1, 0,   1,   8'h00, 1);
        step(0, 0, 0, 32'h0,  0, 32'h0,    32'h105, 1, 0,   1,   8'h01, 1);
        // three-cycle stall at 0x105
        step(0, 1, 0, 32'h0,  0, 32'h0,    32'h105, 1, 0,   1,   8'h0,  0);
        step(0, 1, 0, 32'h0,  0, 32'h0,    32'h105, 1, 0,   1,   8'h0,  0);
        step(0, 1, 0, 32'h0,  0, 32'h0,    32'h105, 1, 0,   1,   8'h0,  0);
        step(0, 0, 0, 32'h0,  0, 32'h0,    32'h106, 1, 0,   1,   8'h0,  0);
        // branch during stall, applied at release
        step(0, 1, 0, 32'h0,  1, 32'h200,  32'h106, 1, 1,   1,   8'h0,  0);
        step(0, 1, 0, 32'h0,  0, 32'h0,    32'h106, 1, 1,   1,   8'h0,  0);
        step(0, 0, 0, 32'h0,  0, 32'h0,    32'h200, 1, 0,   1,   8'h0,  0);
        step(0, 0, 0, 32'h0,  0, 32'h0,    32'h201, 1, 0,   1,   8'h0,  0);
        // newer branch in the same stall overwrites the buffer
        step(0, 1, 0, 32'h0,  1, 32'h280,  32'h201, 1, 1,   1,   8'h0,  0);
        step(0, 1, 0, 32'h0,  1, 32'h2A0,  32'h201, 1, 1,   1,   8'h0,  0);
        step(0, 0, 0, 32'h0,  0, 32'h0,    32'h2A0, 1, 0,   1,   8'h0,  0);
        step(0, 0, 0, 32'h0,  0, 32'h0,    32'h2A1, 1, 0,   1,   8'h0,  0);
        // new branch at release beats the buffered one
        step(0, 1, 0, 32'h0,  1, 32'h400,  32'h2A1, 1, 1,   1,   8'h0,  0);
        step(0, 0, 0, 32'h0,  1, 32'h500,  32'h500, 1, 0,   1,   8'h0,  0);
        step(0, 0, 0, 32'h0,  0, 32'h0,    32'h501, 1, 0,   1,   8'h0,  0);
        // flush with branch and stall, while a branch is pending
        step(0, 1, 0, 32'h0,  1, 32'h600,  32'h501, 1, 1,   1,   8'h0,  0);
        step(0, 1, 1, 32'h80, 1, 32'h300,  32'h80,  1, 0,   1,   8'h0,  0);
        step(0, 0, 0, 32'h0,  0, 32'h0,    32'h81,  1, 0,   1,   8'h0,  0);
        // direct branch
        step(0, 0, 0, 32'h0,  1, 32'h700,  32'h700, 1, 0,   1,   8'h0,  0);
        step(0, 0, 0, 32'h0,  0, 32'h0,    32'h701, 1, 0,   1,   8'h0,  0);
        // reset while a branch is pending
        step(0, 1, 0, 32'h0,  1, 32'h900,  32'h701, 1, 1,   1,   8'h0,  0);
        step(1, 1, 0, 32'h0,  0, 32'h0,    32'h701, 0, 0,   1,   8'h0,  0);
        step(0, 1, 0, 32'h0,  1, 32'hA00,  32'h100, 1, 0,   1,   8'h0,  0);
        step(0, 0, 0, 32'h0,  0, 32'h0,    32'h101, 1, 0,   1,   8'h0,  0);
        step(0, 0, 0, 32'h0,  0, 32'h0,    32'h102, 1, 0,   1,   8'h0,  0);

        for (int unsigned i = 0; i < 10 && sbq.size() > 0; i++)
            @(posedge clk);
        #2;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d entries left expected 0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
